// File: rtl/chiplet_pkt_builder.sv
`default_nettype none
// ============================================================================
// chiplet_pkt_builder : TX packetizer, command + write data -> framed flits
//                       (hdr, addr, data, crc). Optional: PKT_BUILDER_CRC_EN
// Revision: 1.0
// ============================================================================
module chiplet_pkt_builder #(
  parameter logic [4:0] NODE_ID   = 5'd0,
  parameter int         LONG_MAX  = 128,
  parameter int         SHORT_MAX = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_fmt,
  input  logic [4:0]  req_dest,
  input  logic [31:0] req_addr,
  input  logic [6:0]  req_len,
  input  logic [3:0]  req_fst_b,
  input  logic [3:0]  req_lst_b,
  input  logic        req_vc,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  output logic        out_valid,
  output logic [39:0] out_flit,
  input  logic        out_ready,
  output logic        busy,
  output logic        fmt_err
);

  localparam logic [3:0] FMT_LONG_READ   = 4'h0;
  localparam logic [3:0] FMT_LONG_WRITE  = 4'h1;
  localparam logic [3:0] FMT_SHORT_READ  = 4'h8;
  localparam logic [3:0] FMT_SHORT_WRITE = 4'h9;
  localparam logic [7:0] LONG_WORDS      = 8'(LONG_MAX);
  localparam logic [7:0] SHORT_WORDS     = 8'(SHORT_MAX);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HDR  = 3'd1,
    ADDR = 3'd2,
    DATA = 3'd3,
    CRC  = 3'd4
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  fmt_q;
  logic [4:0]  dest_q;
  logic [31:0] addr_q;
  logic [6:0]  len_q;
  logic [3:0]  fst_q, lst_q;
  logic        vc_q;
  logic [1:0]  pkt_id;
  logic [7:0]  cnt;
  logic [39:0] flit_q, flit_d;
  logic        valid_q, valid_d;

  logic        legal, hs, last_word;
  logic        q_long;
  logic [7:0]  word_n;
  logic [3:0]  s_fmt;
  logic [4:0]  s_dest;
  logic [31:0] s_addr;
  logic [6:0]  s_len;
  logic [3:0]  s_fst, s_lst;
  logic        s_vc;
  logic        s_long;
  logic [31:0] hdr_word;
  logic [7:0]  meta;
  logic [31:0] crc_pay;

  assign legal = (req_fmt == FMT_LONG_READ)  || (req_fmt == FMT_LONG_WRITE) ||
                 (req_fmt == FMT_SHORT_READ) || (req_fmt == FMT_SHORT_WRITE);

  // DATA is a zero-latency pass-through; the other states drive from registers.
  assign out_valid = (state == DATA) ? wdata_valid : valid_q;
  assign out_flit  = (state == DATA) ? {vc_q, pkt_id, NODE_ID, wdata} : flit_q;
  assign hs        = out_valid && out_ready;
  assign busy      = (state != IDLE);

  assign q_long    = (fmt_q == FMT_LONG_READ) || (fmt_q == FMT_LONG_WRITE);
  assign word_n    = q_long ? ((len_q == 7'd0) ? LONG_WORDS : {1'b0, len_q})
                            : ((len_q[3:0] == 4'd0) ? SHORT_WORDS : {4'b0, len_q[3:0]});
  assign last_word = (cnt == (word_n - 8'd1));

  // The header is built on the accept cycle, before the fields are latched.
  assign s_fmt  = (state == IDLE) ? req_fmt   : fmt_q;
  assign s_dest = (state == IDLE) ? req_dest  : dest_q;
  assign s_addr = (state == IDLE) ? req_addr  : addr_q;
  assign s_len  = (state == IDLE) ? req_len   : len_q;
  assign s_fst  = (state == IDLE) ? req_fst_b : fst_q;
  assign s_lst  = (state == IDLE) ? req_lst_b : lst_q;
  assign s_vc   = (state == IDLE) ? req_vc    : vc_q;
  assign s_long = (s_fmt == FMT_LONG_READ) || (s_fmt == FMT_LONG_WRITE);

  assign hdr_word = s_long ? {s_fmt, s_dest, 8'h00, s_lst, s_fst, s_len}
                           : {s_fmt, s_dest, s_addr[18:0], s_len[3:0]};
  assign meta     = {s_vc, pkt_id, NODE_ID};

`ifdef PKT_BUILDER_CRC_EN
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  logic [31:0] crc, crc_d;

  function automatic logic [31:0] crc32_upd(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? CRC_POLY : 32'h0);
    end
    return r;
  endfunction

  // CRC covers every handshaked flit up to, not including, the CRC flit.
  always_comb begin
    crc_d = crc;
    if (hs && (state != CRC) && (state != IDLE)) crc_d = crc32_upd(crc, out_flit[31:0]);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                     crc <= CRC_INIT;
    else if (hs && (state == CRC)) crc <= CRC_INIT;
    else                           crc <= crc_d;
  end

  assign crc_pay = crc_d;
`else
  assign crc_pay = 32'h0;
`endif

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    wdata_ready = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && legal) state_nx = HDR;
      end
      HDR: begin
        if (hs) begin
          if (q_long)                        state_nx = ADDR;
          else if (fmt_q == FMT_SHORT_WRITE) state_nx = DATA;
          else                               state_nx = CRC;
        end
      end
      ADDR: begin
        if (hs) state_nx = (fmt_q == FMT_LONG_WRITE) ? DATA : CRC;
      end
      DATA: begin
        wdata_ready = out_ready;
        if (hs && last_word) state_nx = CRC;
      end
      CRC: begin
        if (hs) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    flit_d  = 40'h0;
    valid_d = 1'b0;
    case (state_nx)
      HDR: begin
        flit_d  = {meta, hdr_word};
        valid_d = 1'b1;
      end
      ADDR: begin
        flit_d  = {meta, s_addr};
        valid_d = 1'b1;
      end
      CRC: begin
        flit_d  = {meta, crc_pay};
        valid_d = 1'b1;
      end
      default: begin
        flit_d  = 40'h0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      flit_q  <= 40'h0;
      valid_q <= 1'b0;
      fmt_err <= 1'b0;
      pkt_id  <= 2'd0;
      cnt     <= 8'd0;
      fmt_q   <= 4'h0;
      dest_q  <= 5'd0;
      addr_q  <= 32'h0;
      len_q   <= 7'd0;
      fst_q   <= 4'h0;
      lst_q   <= 4'h0;
      vc_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      flit_q  <= flit_d;
      valid_q <= valid_d;
      fmt_err <= (state == IDLE) && req_valid && !legal;
      if ((state == IDLE) && req_valid && legal) begin
        fmt_q  <= req_fmt;
        dest_q <= req_dest;
        addr_q <= req_addr;
        len_q  <= req_len;
        fst_q  <= req_fst_b;
        lst_q  <= req_lst_b;
        vc_q   <= req_vc;
      end
      if ((state == DATA) && hs) cnt <= last_word ? 8'd0 : cnt + 8'd1;
      if ((state == CRC) && hs)  pkt_id <= pkt_id + 2'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_chiplet_pkt_builder.sv
`default_nettype none
// ============================================================================
// tb_chiplet_pkt_builder : directed bench for chiplet_pkt_builder
// Revision: 1.0
// ============================================================================
module tb_chiplet_pkt_builder;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_fmt = 4'h0;
  logic [4:0]  req_dest = 5'd0;
  logic [31:0] req_addr = 32'h0;
  logic [6:0]  req_len = 7'd0;
  logic [3:0]  req_fst_b = 4'h0;
  logic [3:0]  req_lst_b = 4'h0;
  logic        req_vc = 1'b0;
  logic        wdata_valid = 1'b0;
  logic [31:0] wdata = 32'h0;
  logic        wdata_ready;
  logic        out_valid;
  logic [39:0] out_flit;
  logic        out_ready = 1'b1;
  logic        busy;
  logic        fmt_err;

  chiplet_pkt_builder dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_fmt(req_fmt),
    .req_dest(req_dest), .req_addr(req_addr), .req_len(req_len),
    .req_fst_b(req_fst_b), .req_lst_b(req_lst_b), .req_vc(req_vc),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .out_valid(out_valid), .out_flit(out_flit), .out_ready(out_ready),
    .busy(busy), .fmt_err(fmt_err)
  );

  always #5 CLK = ~CLK;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [39:0] rx [0:255];
  int          rx_n, dcons, busy_cyc;
  logic [1:0]  exp_id;

  task automatic check(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference CRC: fold the whole word in, then shift out 32 bits.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] w);
    logic [31:0] r;
    r = c ^ w;
    for (int i = 0; i < 32; i++) r = r[31] ? ((r << 1) ^ 32'h04C11DB7) : (r << 1);
    return r;
  endfunction

  function automatic logic [31:0] crc_exp(input logic [31:0] c);
`ifdef PKT_BUILDER_CRC_EN
    return c;
`else
    return 32'h0 & c;
`endif
  endfunction

  task automatic do_reset();
    req_valid = 1'b0; wdata_valid = 1'b0; out_ready = 1'b1;
    nRST = 1'b0;
    #3;
    check("rst_req_ready",   {39'h0, req_ready},   40'h1);
    check("rst_out_valid",   {39'h0, out_valid},   40'h0);
    check("rst_out_flit",    out_flit,             40'h0);
    check("rst_wdata_ready", {39'h0, wdata_ready}, 40'h0);
    check("rst_busy",        {39'h0, busy},        40'h0);
    check("rst_fmt_err",     {39'h0, fmt_err},     40'h0);
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;
    exp_id = 2'd0;
  endtask

  // Sends one command and collects flits until nflits have handshaked.
  task automatic run_pkt(input logic [3:0] fmt, input logic [4:0] dest, input logic [31:0] addr,
                         input logic [6:0] len, input logic [3:0] fst, input logic [3:0] lst,
                         input logic vc, input int nflits, input int ndata, input bit rnd);
    int guard, didx;
    logic prev_stall, consumed;
    logic [39:0] prev_flit;
    rx_n = 0; dcons = 0; busy_cyc = 0; didx = 0; prev_stall = 1'b0; consumed = 1'b0;
    prev_flit = 40'h0;
    req_fmt = fmt; req_dest = dest; req_addr = addr; req_len = len;
    req_fst_b = fst; req_lst_b = lst; req_vc = vc; req_valid = 1'b1;
    @(negedge CLK);
    check("cmd_ready", {39'h0, req_ready}, 40'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    guard = 0;
    while (rx_n < nflits && guard < 2000) begin
      if (!(wdata_valid && !consumed)) begin
        wdata_valid = (didx < ndata) && (rnd ? !wdata_valid : 1'b1);
        wdata       = 32'(didx + 1);
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge CLK);
      busy_cyc += busy ? 1 : 0;
      check("req_ready_busy", {39'h0, req_ready}, 40'h0);
      if (prev_stall && out_valid) check("stall_stable", out_flit, prev_flit);
      if (out_valid && out_ready) begin
        rx[rx_n] = out_flit;
        rx_n++;
      end
      consumed = wdata_valid && wdata_ready;
      if (consumed) begin
        dcons++;
        didx++;
      end
      prev_stall = out_valid && !out_ready;
      prev_flit  = out_flit;
      @(posedge CLK); #1;
      guard++;
    end
    wdata_valid = 1'b0;
    out_ready   = 1'b1;
    check("pkt_no_timeout", {39'h0, guard < 2000}, 40'h1);
    check("pkt_flits", 40'(rx_n), 40'(nflits));
    check("pkt_data",  40'(dcons), 40'(ndata));
    for (int i = 0; i < rx_n; i++) check("meta", {32'h0, rx[i][39:32]}, {32'h0, vc, exp_id, 5'd0});
    exp_id = exp_id + 2'd1;
  endtask

  logic [31:0] hdr, c;
  logic [1:0]  id_seq [0:4];
  int          guard;

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    id_seq[0] = 2'd0; id_seq[1] = 2'd1; id_seq[2] = 2'd2; id_seq[3] = 2'd3; id_seq[4] = 2'd0;
    do_reset();

    // SHORT_READ: header + CRC only
    run_pkt(4'h8, 5'd3, 32'h0000_1234, 7'd0, 4'h0, 4'h0, 1'b0, 2, 0, 1'b0);
    hdr = {4'h8, 5'd3, 19'h1234, 4'h0};
    check("sr_hdr", {8'h0, rx[0][31:0]}, {8'h0, hdr});
    check("sr_crc", {8'h0, rx[1][31:0]}, {8'h0, crc_exp(crc_step(32'hFFFFFFFF, hdr))});
    check("sr_busy_cycles", 40'(busy_cyc), 40'd2);
    check("sr_idle_after", {39'h0, busy}, 40'h0);

    // LONG_WRITE len=4 with bursty valid and random ready
    run_pkt(4'h1, 5'd7, 32'hA000_0040, 7'd4, 4'hF, 4'h3, 1'b1, 7, 4, 1'b1);
    hdr = {4'h1, 5'd7, 8'h00, 4'h3, 4'hF, 7'd4};
    check("lw_hdr",  {8'h0, rx[0][31:0]}, {8'h0, hdr});
    check("lw_addr", {8'h0, rx[1][31:0]}, 40'hA000_0040);
    c = crc_step(32'hFFFFFFFF, hdr);
    c = crc_step(c, 32'hA000_0040);
    for (int k = 0; k < 4; k++) begin
      check("lw_data", {8'h0, rx[2+k][31:0]}, 40'(k + 1));
      c = crc_step(c, 32'(k + 1));
    end
    check("lw_crc", {8'h0, rx[6][31:0]}, {8'h0, crc_exp(c)});

    // LONG_WRITE len=0 -> 128 words
    run_pkt(4'h1, 5'd2, 32'h0000_1000, 7'd0, 4'hF, 4'hF, 1'b0, 131, 128, 1'b0);
    hdr = {4'h1, 5'd2, 8'h00, 4'hF, 4'hF, 7'd0};
    check("lw0_hdr", {8'h0, rx[0][31:0]}, {8'h0, hdr});
    c = crc_step(crc_step(32'hFFFFFFFF, hdr), 32'h0000_1000);
    for (int k = 0; k < 128; k++) begin
      check("lw0_data", {8'h0, rx[2+k][31:0]}, 40'(k + 1));
      c = crc_step(c, 32'(k + 1));
    end
    check("lw0_crc", {8'h0, rx[130][31:0]}, {8'h0, crc_exp(c)});

    // SHORT_WRITE len=0 -> 16 words
    run_pkt(4'h9, 5'd5, 32'h0007_FFFC, 7'd0, 4'h0, 4'h0, 1'b1, 18, 16, 1'b0);
    hdr = {4'h9, 5'd5, 19'h7FFFC, 4'h0};
    check("sw0_hdr", {8'h0, rx[0][31:0]}, {8'h0, hdr});
    c = crc_step(32'hFFFFFFFF, hdr);
    for (int k = 0; k < 16; k++) c = crc_step(c, 32'(k + 1));
    check("sw0_last", {8'h0, rx[16][31:0]}, 40'd16);
    check("sw0_crc", {8'h0, rx[17][31:0]}, {8'h0, crc_exp(c)});

    // Five back-to-back LONG_READs from a fresh id
    do_reset();
    for (int p = 0; p < 5; p++) begin
      run_pkt(4'h0, 5'd9, 32'h0000_0100 + 32'(p), 7'd1, 4'h1, 4'h2, 1'b0, 3, 0, 1'b0);
      check("lr_id", {38'h0, rx[0][38:37]}, {38'h0, id_seq[p]});
      check("lr_addr", {8'h0, rx[1][31:0]}, {8'h0, 32'h0000_0100 + 32'(p)});
      check("lr_gap_ready", {39'h0, req_ready}, 40'h1);
    end
    hdr = {4'h0, 5'd9, 8'h00, 4'h2, 4'h1, 7'd1};
    check("lr_hdr", {8'h0, rx[0][31:0]}, {8'h0, hdr});
    check("lr_crc", {8'h0, rx[2][31:0]},
          {8'h0, crc_exp(crc_step(crc_step(32'hFFFFFFFF, hdr), 32'h0000_0104))});

    // Illegal format is dropped with a one-cycle error pulse
    req_fmt = 4'h5; req_valid = 1'b1;
    @(negedge CLK);
    check("bad_ready", {39'h0, req_ready}, 40'h1);
    @(posedge CLK); #1;
    req_valid = 1'b0;
    @(negedge CLK);
    check("bad_err_pulse", {39'h0, fmt_err},   40'h1);
    check("bad_no_flit",   {39'h0, out_valid}, 40'h0);
    check("bad_not_busy",  {39'h0, busy},      40'h0);
    check("bad_ready2",    {39'h0, req_ready}, 40'h1);
    @(posedge CLK); #1;
    @(negedge CLK);
    check("bad_err_clear", {39'h0, fmt_err},   40'h0);
    check("bad_no_flit2",  {39'h0, out_valid}, 40'h0);
    @(posedge CLK); #1;
    run_pkt(4'h8, 5'd1, 32'h0000_0ABC, 7'd3, 4'h0, 4'h0, 1'b0, 2, 0, 1'b0);
    check("bad_next_hdr", {8'h0, rx[0][31:0]}, {8'h0, 4'h8, 5'd1, 19'h00ABC, 4'h3});

    // Async reset in the middle of a LONG_WRITE len=8
    req_fmt = 4'h1; req_dest = 5'd4; req_addr = 32'h0000_2000; req_len = 7'd8;
    req_fst_b = 4'hF; req_lst_b = 4'hF; req_vc = 1'b1; req_valid = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0; wdata_valid = 1'b1; wdata = 32'd1; out_ready = 1'b1;
    guard = 0;
    @(negedge CLK);
    while (!wdata_ready && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("mid_reached_data", {39'h0, wdata_ready}, 40'h1);
    @(posedge CLK); #1;
    wdata = 32'd2;
    #2;
    check("mid_in_data", {39'h0, busy}, 40'h1);
    nRST = 1'b0;
    #1;
    check("mid_out_valid",   {39'h0, out_valid},   40'h0);
    check("mid_out_flit",    out_flit,             40'h0);
    check("mid_busy",        {39'h0, busy},        40'h0);
    check("mid_req_ready",   {39'h0, req_ready},   40'h1);
    check("mid_wdata_ready", {39'h0, wdata_ready}, 40'h0);
    wdata_valid = 1'b0;
    @(negedge CLK) nRST = 1'b1;
    @(posedge CLK); #1;
    exp_id = 2'd0;
    run_pkt(4'h9, 5'd1, 32'h0000_0055, 7'd2, 4'h0, 4'h0, 1'b0, 4, 2, 1'b0);
    hdr = {4'h9, 5'd1, 19'h00055, 4'h2};
    check("post_rst_hdr", {8'h0, rx[0][31:0]}, {8'h0, hdr});
    check("post_rst_id",  {38'h0, rx[0][38:37]}, 40'h0);
    c = crc_step(crc_step(crc_step(32'hFFFFFFFF, hdr), 32'd1), 32'd2);
    check("post_rst_crc", {8'h0, rx[3][31:0]}, {8'h0, crc_exp(c)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chiplet_pkt_builder.md
Name: chiplet_pkt_builder

Overview:
- Transmit-side packetizer for the chiplet interconnect.
- Accepts one request command plus a stream of write-data words, and emits a framed flit stream: header, address (long formats), data, CRC.
- Flit count per packet equals what the receive-side flit-count decoder expects for the same header.
- Sits between an endpoint request master and the switch/PHY TX queue.

Parameters:
- NODE_ID, 5'd0, node_id_t value driven into flit metadata.req for every flit.
- LONG_MAX, 128, word count encoded by long length field 0.
- SHORT_MAX, 16, word count encoded by short length field 0.

Ports:
- CLK  in  1  clock.
- nRST  in  1  async active-low reset.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when req_valid && req_ready.
- req_fmt  in  4  format_e; legal: FMT_LONG_READ, FMT_LONG_WRITE, FMT_SHORT_READ, FMT_SHORT_WRITE.
- req_dest  in  5  destination node.
- req_addr  in  32  byte address.
- req_len  in  7  data words; 0 = max; short formats use [3:0] only.
- req_fst_b  in  4  first-word byte enables (long only).
- req_lst_b  in  4  last-word byte enables (long only).
- req_vc  in  1  virtual channel for all flits of the packet.
- wdata_valid  in  1  write-data word valid.
- wdata  in  32  write-data word.
- wdata_ready  out  1  word consumed when wdata_valid && wdata_ready.
- out_valid  out  1  flit valid.
- out_flit  out  flit_t (40)  {vc, id, req, payload}.
- out_ready  in  1  downstream accept.
- busy  out  1  state != IDLE.
- fmt_err  out  1  one-cycle pulse on an illegal-format command.

Behaviour:
- Reset: state IDLE, req_ready=1, out_valid=0, out_flit=0, wdata_ready=0, busy=0, fmt_err=0, pkt_id=0, crc=32'hFFFFFFFF, word counter=0.
- FSM states: IDLE, HDR, ADDR, DATA, CRC.
- IDLE:
  - req_ready=1.
  - On accept with a legal fmt: latch all req_* fields, go to HDR.
  - On accept with an illegal fmt: drop the command, pulse fmt_err next cycle, stay IDLE.
- HDR:
  - out_valid=1.
  - Long payload: long_hdr_t {fmt, dest, r0=0, lst_b, fst_b, length=req_len}.
  - Short payload: short_hdr_t {fmt, dest, addr=req_addr[18:0], length=req_len[3:0]}.
  - On out_ready: long formats go to ADDR; SHORT_WRITE goes to DATA; SHORT_READ goes to CRC.
- ADDR: payload=req_addr. On handshake: LONG_WRITE goes to DATA; LONG_READ goes to CRC.
- DATA:
  - Pass-through: out_valid=wdata_valid, wdata_ready=out_ready, payload=wdata.
  - Combinational path, zero latency.
  - Word count N = req_len, or LONG_MAX/SHORT_MAX when the field is 0.
  - Counter increments per handshake; on the Nth handshake go to CRC.
  - Stall on either side holds state; out_flit must not change while out_valid && !out_ready.
- CRC:
  - payload=crc value. On handshake: go to IDLE, pkt_id+=1 (2-bit wrap 3->0), crc reinitialised.
- Metadata: all flits of a packet carry the same vc=latched req_vc, id=pkt_id, req=NODE_ID.
- Registered outputs: out_valid and out_flit are registered in HDR, ADDR and CRC (state-decoded, no combinational input dependence).
- Packet length: total flits = 3 long read, 3+N long write, 2 short read, 2+N short write.
- CRC computation:
  - CRC-32, polynomial 0x04C11DB7, init 0xFFFFFFFF, non-reflected, no final XOR.
  - Updates with the 32-bit payload of each handshaked flit from HDR through the last DATA flit, MSB first, one word per cycle.
- req_ready is 0 outside IDLE; there is no command queueing. A new command is accepted the cycle after the CRC handshake returns to IDLE.
- wdata_ready is 0 outside DATA; extra data words offered early are not consumed.
- An async nRST assertion mid-packet aborts immediately to reset values; the partial packet is not completed.

Optional Feature:
- Macro: PKT_BUILDER_CRC_EN.
- Defined: CRC flit carries the computed CRC-32 as above.
- Undefined: CRC logic is removed and the CRC flit payload is 32'h0. The flit is still emitted, so flit counts are unchanged.

Test Plan:
- SHORT_READ, dest=5'd3, addr=19'h1234, out_ready=1: 2 flits; hdr payload = {4'h8, 5'd3, 19'h1234, 4'h0}; flit 2 = CRC; id=0; busy for 2 cycles.
- LONG_WRITE, len=4, data 1,2,3,4, wdata_valid toggling 1/0 and out_ready random: exactly 7 flits in order hdr, addr, 1, 2, 3, 4, crc; out_flit stable during stalls; CRC matches the software model.
- LONG_WRITE, len=0: 131 flits, 128 data words consumed; counter does not wrap early. SHORT_WRITE, len=0: 18 flits.
- 5 back-to-back LONG_READ: metadata id sequence 0, 1, 2, 3, 0; req_ready high only in IDLE; one-cycle gap between packets.
- req_fmt=4'h5: no flits emitted, fmt_err pulses once, req_ready remains 1; a following legal command is processed normally.
- nRST asserted during DATA word 2 of len=8: outputs go to reset values immediately; the next packet starts with a fresh header and id=0.
